// File: rtl/dmem_responder.sv
// Data-memory responder: word SRAM with byte lanes,
// MMIO cycle/tohost/scratch window and fault capture.
module dmem_responder #(
  parameter int XLEN = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MEM_BASE = '0,
  parameter logic [XLEN-1:0] MMIO_BASE = 'h1000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              External_MemEn,
  input  logic              External_MemWriteEn,
  input  logic [XLEN/8-1:0] External_MemWriteByteEn,
  input  logic [XLEN-1:0]   External_MemAdr,
  input  logic [XLEN-1:0]   External_MemWriteData,
  output logic [XLEN-1:0]   External_MemReadData,
  output logic              Halt,
  output logic [XLEN-1:0]   ToHost,
  output logic              AccessFault,
  output logic [XLEN-1:0]   FaultAdr
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS = $clog2(BYTES);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int TOP = OFS + AW;

  localparam logic [XLEN-1:0] CYC_ADR = MMIO_BASE;
  localparam logic [XLEN-1:0] TH_ADR =
    MMIO_BASE + XLEN'(BYTES);
  localparam logic [XLEN-1:0] SC_ADR =
    MMIO_BASE + XLEN'(2 * BYTES);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] cycle_q;
  logic [XLEN-1:0] scratch_q;
  logic [XLEN-1:0] rd_mux;
  logic [XLEN-1:0] th_merged;
  logic [XLEN-1:0] sc_merged;
  logic [AW-1:0]   idx;
  logic [XLEN-OFS-1:0] wadr;
  logic hit_arr;
  logic hit_cyc;
  logic hit_th;
  logic hit_sc;
  logic mapped;
  logic rd_req;
  logic wr_req;

  function automatic logic [XLEN-1:0] merge(
    input logic [XLEN-1:0]  old,
    input logic [XLEN-1:0]  wd,
    input logic [BYTES-1:0] be
  );
    logic [XLEN-1:0] r;
    r = old;
    for (int i = 0; i < BYTES; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign wadr = External_MemAdr[XLEN-1:OFS];
  assign idx = External_MemAdr[TOP-1:OFS];
  assign hit_arr =
    External_MemAdr[XLEN-1:TOP] == MEM_BASE[XLEN-1:TOP];
  assign hit_cyc = wadr == CYC_ADR[XLEN-1:OFS];
  assign hit_th = wadr == TH_ADR[XLEN-1:OFS];
  assign hit_sc = wadr == SC_ADR[XLEN-1:OFS];
  assign mapped = hit_arr | hit_cyc | hit_th | hit_sc;

  assign rd_req =
    reset_n & External_MemEn & ~External_MemWriteEn;
  assign wr_req =
    reset_n & External_MemEn & External_MemWriteEn;

  assign th_merged = merge(ToHost, External_MemWriteData,
                           External_MemWriteByteEn);
  assign sc_merged = merge(scratch_q, External_MemWriteData,
                           External_MemWriteByteEn);

  // Read source select; regions never overlap.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_arr: rd_mux = mem[idx];
      hit_cyc: rd_mux = cycle_q;
      hit_th:  rd_mux = ToHost;
      hit_sc:  rd_mux = scratch_q;
      default: rd_mux = '0;
    endcase
  end

  // Array byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_req && hit_arr) begin
      for (int i = 0; i < BYTES; i++)
        if (External_MemWriteByteEn[i])
          mem[idx][8*i +: 8] <=
            External_MemWriteData[8*i +: 8];
    end
  end

  // Registered read port, MMIO registers and fault capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      External_MemReadData <= '0;
      cycle_q <= '0;
      scratch_q <= '0;
      ToHost <= '0;
      Halt <= 1'b0;
      AccessFault <= 1'b0;
      FaultAdr <= '0;
    end else begin
      cycle_q <= cycle_q + XLEN'(1);
      if (rd_req)
        External_MemReadData <= rd_mux;
      if (wr_req && hit_th) begin
        ToHost <= th_merged;
        if (th_merged[0]) Halt <= 1'b1;
      end
      if (wr_req && hit_sc)
        scratch_q <= sc_merged;
      if ((rd_req || wr_req) && !mapped) begin
        AccessFault <= 1'b1;
        if (!AccessFault) FaultAdr <= External_MemAdr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: reads push
// expected data, a monitor pops it after each read edge.
module tb_dmem_responder;

  localparam logic [31:0] CYC = 32'h1000_0000;
  localparam logic [31:0] TH  = 32'h1000_0004;
  localparam logic [31:0] SC  = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rdata;
  logic        halt;
  logic [31:0] tohost;
  logic        fault;
  logic [31:0] fadr;

  int npass = 0;
  int ntot = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk),
    .reset_n(reset_n),
    .External_MemEn(en),
    .External_MemWriteEn(we),
    .External_MemWriteByteEn(be),
    .External_MemAdr(adr),
    .External_MemWriteData(wd),
    .External_MemReadData(rdata),
    .Halt(halt),
    .ToHost(tohost),
    .AccessFault(fault),
    .FaultAdr(fadr)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b0;
    we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] b);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    we = 1'b1;
    adr = a;
    wd = d;
    be = b;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [31:0] e);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    we = 1'b0;
    adr = a;
    be = 4'h0;
    exp_q.push_back(e);
  endtask

  // Monitor: after every accepted read edge, pop and compare.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      if (reset_n && en && !we) begin
        #1;
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", rdata, 32'hx);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata, e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    repeat (5) idle();
    chk("rst_rdata", rdata, 0);
    chk("rst_halt", {31'b0, halt}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_tohost", tohost, 0);
    rd(CYC, 32'd5);

    wr(32'h8, 32'h1122_3344, 4'hF);
    wr(32'h8, 32'hAABB_CCDD, 4'h5);
    rd(32'h8, 32'h11BB_33DD);
    wr(32'h8, 32'hDEAD_BEEF, 4'h0);
    rd(32'h8, 32'h11BB_33DD);

    wr(32'h0, 32'd1, 4'hF);
    wr(32'h4, 32'd2, 4'hF);
    wr(32'h8, 32'd3, 4'hF);
    rd(32'h0, 32'd1);
    rd(32'h4, 32'd2);
    rd(32'h8, 32'd3);
    idle();
    idle();
    chk("idle_hold", rdata, 32'd3);

    wr(32'hC, 32'h55, 4'hF);
    rd(32'hC, 32'h55);
    wr(32'hFFC, 32'hCAFE_0123, 4'hF);
    rd(32'hFFC, 32'hCAFE_0123);

    wr(TH, 32'h2, 4'hF);
    idle();
    chk("tohost2", tohost, 32'h2);
    chk("halt_off", {31'b0, halt}, 0);
    wr(TH, 32'h1, 4'hF);
    idle();
    chk("halt_set", {31'b0, halt}, 1);
    wr(TH, 32'h0, 4'hF);
    idle();
    chk("halt_sticky", {31'b0, halt}, 1);
    chk("tohost0", tohost, 0);
    wr(TH, 32'hFFFF_0100, 4'h2);
    rd(TH, 32'h0000_0100);

    wr(SC, 32'h1234_5678, 4'hF);
    wr(SC, 32'hAB00_0000, 4'h8);
    rd(SC, 32'hAB34_5678);
    idle();
    chk("no_fault_yet", {31'b0, fault}, 0);

    rd(32'h2000_0004, 32'h0);
    wr(32'h3000_0000, 32'h9, 4'hF);
    idle();
    chk("fault_set", {31'b0, fault}, 1);
    chk("fault_adr", fadr, 32'h2000_0004);
    rd(32'h1000, 32'h0);
    idle();
    chk("fault_adr_keep", fadr, 32'h2000_0004);

    @(negedge clk);
    reset_n = 1'b0;
    en = 1'b1;
    we = 1'b1;
    adr = SC;
    wd = 32'h7777_7777;
    be = 4'hF;
    idle();
    chk("rst2_fault", {31'b0, fault}, 0);
    chk("rst2_halt", {31'b0, halt}, 0);
    rd(SC, 32'h0);
    wr(CYC, 32'hFFFF_FFFF, 4'hF);
    rd(CYC, 32'd3);
    rd(32'h8, 32'd3);
    idle();
    chk("cyc_wr_nofault", {31'b0, fault}, 0);

    rd(32'h2000_0006, 32'h0);
    idle();
    chk("fault_lowbits", fadr, 32'h2000_0006);

    repeat (3) idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
